// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared AES definitions for the sequential InvSubBytes block: widths,
// FSM state encoding and the inverse S-box table.
package inv_sub_bytes_seq_pkg;

  localparam int STATE_W     = 128;
  localparam int BYTE_W      = 8;
  localparam int STATE_BYTES = STATE_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte in, one byte out.
module inv_sbox
  import inv_sub_bytes_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] in_i,
  output logic [BYTE_W-1:0] out_o
);

  assign out_o = INV_SBOX[in_i];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes: captures one 128-bit state and substitutes
// BYTES_PER_CYCLE bytes per clock, then holds the result until taken.
module inv_sub_bytes_seq
  import inv_sub_bytes_seq_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:STATE_W-1] shifted_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:STATE_W-1] sub_state,
  output logic               busy
);

  localparam int N      = STATE_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W  = $clog2(STATE_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  fsm_e               state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [0:STATE_W-1] data_q, data_d;
  logic [BYTE_W-1:0]  sb_in  [BYTES_PER_CYCLE];
  logic [BYTE_W-1:0]  sb_out [BYTES_PER_CYCLE];

  // Chunk c covers bytes c*BPC .. c*BPC+BPC-1 of the state register.
  always_comb begin
    sb_in = '{default: '0};
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      sb_in[i] = data_q[IDX_W'((int'(cnt_q) * BYTES_PER_CYCLE + i) * BYTE_W) +: BYTE_W];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .in_i  (sb_in[g]),
      .out_o (sb_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = shifted_state;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
          data_d[IDX_W'((int'(cnt_q) * BYTES_PER_CYCLE + i) * BYTE_W) +: BYTE_W] = sb_out[i];
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // All handshake outputs are Moore so no input-to-output combinational path exists.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sub_state = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq at BYTES_PER_CYCLE = 4, 1 and 16.
module tb_inv_sub_bytes_seq;

  logic         clk;
  logic         rst_n;
  logic [0:127] shifted_state;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [0:127] sub_state [3];
  logic         busy      [3];

  int checks = 0;
  int errors = 0;

  localparam logic [0:127] ALL_63  = {16{8'h63}};
  localparam logic [0:127] ALL_00  = {16{8'h00}};
  localparam logic [0:127] PAT_IN  = {4{32'h0063EDFF}};
  localparam logic [0:127] PAT_EXP = {4{32'h5200537D}};

  // dut index 0: BPC=4, 1: BPC=1, 2: BPC=16
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .shifted_state(shifted_state), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sub_state(sub_state[0]), .busy(busy[0]));

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .shifted_state(shifted_state), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sub_state(sub_state[1]), .busy(busy[1]));

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .shifted_state(shifted_state), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sub_state(sub_state[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    shifted_state = '0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || sub_state[d] !== ALL_00) begin
        errors++;
        $display("FAIL reset dut%0d: in_ready=%b out_valid=%b busy=%b sub_state=%h, want 1 0 0 0", d,
                 in_ready[d], out_valid[d], busy[d], sub_state[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector(input int d, input logic [0:127] din, input logic [0:127] exp,
                             input int lat, input string name);
    int e;
    @(negedge clk);
    shifted_state = din;
    in_valid[d]   = 1'b1;
    out_ready[d]  = 1'b1;
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: in_ready=%b want 1", name, in_ready[d]);
    end
    @(posedge clk);
    #1;
    in_valid[d]   = 1'b0;
    shifted_state = '1;
    checks++;
    if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s after_accept: busy=%b in_ready=%b out_valid=%b want 1 0 0", name,
               busy[d], in_ready[d], out_valid[d]);
    end
    e = 0;
    while (out_valid[d] !== 1'b1 && e < 40) begin
      @(posedge clk);
      #1;
      e++;
    end
    checks++;
    if (e != lat || out_valid[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (out_valid=%b) want %0d", name, e, out_valid[d], lat);
    end
    checks++;
    if (sub_state[d] !== exp) begin
      errors++;
      $display("FAIL %s data: got %h want %h", name, sub_state[d], exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s return_idle: out_valid=%b in_ready=%b busy=%b want 0 1 0", name,
               out_valid[d], in_ready[d], busy[d]);
    end
  endtask

  task automatic test_basic();
    test_vector(0, ALL_63, ALL_00, 4, "bpc4_all63");
  endtask

  task automatic test_pattern();
    test_vector(0, PAT_IN, PAT_EXP, 4, "bpc4_pattern");
  endtask

  task automatic test_backpressure();
    int e;
    @(negedge clk);
    shifted_state = PAT_IN;
    in_valid[0]   = 1'b1;
    out_ready[0]  = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    e = 0;
    while (out_valid[0] !== 1'b1 && e < 40) begin
      @(posedge clk);
      #1;
      e++;
    end
    checks++;
    if (e != 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d edges want 4", e);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[0] !== 1'b1 || sub_state[0] !== PAT_EXP) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b sub_state=%h want 1 %h", c, out_valid[0],
                 sub_state[0], PAT_EXP);
      end
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid[0], in_ready[0]);
    end
    out_ready[0] = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    shifted_state = ALL_63;
    in_valid[0]   = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || sub_state[0] !== ALL_00) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b sub_state=%h want 0 0 1 0",
               out_valid[0], busy[0], in_ready[0], sub_state[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_vector(0, PAT_IN, PAT_EXP, 4, "after_reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [7:0] in_tbl  [18];
    logic [7:0] exp_tbl [3];
    int         exp_cyc [3];
    int         seen;
    for (int k = 0; k < 18; k++) in_tbl[k] = 8'h01;
    in_tbl[0]  = 8'h63;
    in_tbl[6]  = 8'hED;
    in_tbl[12] = 8'hFF;
    exp_tbl[0] = 8'h00; exp_cyc[0] = 4;
    exp_tbl[1] = 8'h53; exp_cyc[1] = 10;
    exp_tbl[2] = 8'h7D; exp_cyc[2] = 16;
    seen = 0;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      shifted_state = {16{in_tbl[k]}};
      in_valid[0]   = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid[0] === 1'b1) begin
        checks++;
        if (seen >= 3) begin
          errors++;
          $display("FAIL b2b_extra: unexpected output %h at cycle %0d", sub_state[0], k);
        end else if (k != exp_cyc[seen] || sub_state[0] !== {16{exp_tbl[seen]}}) begin
          errors++;
          $display("FAIL b2b_out%0d: got %h at cycle %0d want %h at cycle %0d", seen, sub_state[0], k,
                   {16{exp_tbl[seen]}}, exp_cyc[seen]);
        end
        seen++;
      end
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs want 3", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bpc_variants();
    test_vector(1, ALL_63, ALL_00, 16, "bpc1_all63");
    test_vector(1, PAT_IN, PAT_EXP, 16, "bpc1_pattern");
    test_vector(2, ALL_63, ALL_00, 1, "bpc16_all63");
    test_vector(2, PAT_IN, PAT_EXP, 1, "bpc16_pattern");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_bpc_variants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
